// File: rtl/writeback_stage.sv
// writeback_stage: selects ALU, load or PC+4 result and drives the register-file write port.
// Optional WB_BYPASS_EN adds byp_valid/byp_rd/byp_data forwarding outputs.
module writeback_stage #(
  parameter int RSP_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_reg_we,
  input  logic [4:0]  in_rd,
  input  logic [1:0]  in_wb_sel,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_pc,
  input  logic [2:0]  in_funct3,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_data,
  output logic        write_enable,
  output logic [4:0]  addr_rd,
  output logic [31:0] data_rd,
  output logic        err_misalign,
`ifdef WB_BYPASS_EN
  output logic        byp_valid,
  output logic [4:0]  byp_rd,
  output logic [31:0] byp_data,
`endif
  output logic        err_timeout
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT_RSP = 1'b1;
  logic [0:0]  state;
  logic [7:0]  cnt;
  logic [4:0]  ld_rd;
  logic        ld_we;
  logic [2:0]  ld_f3;
  logic [1:0]  ld_off;
  logic        accept, misalign;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data;
  assign in_ready = state == IDLE;
  assign accept = in_valid && in_ready;
`ifdef WB_BYPASS_EN
  assign byp_valid = write_enable;
  assign byp_rd = addr_rd;
  assign byp_data = data_rd;
`endif
  // Only legal load widths are ever latched, so funct3[1] alone identifies LW afterwards.
  always_comb begin
    misalign = (in_funct3 == 3'b001 || in_funct3 == 3'b101) ? in_alu[0] :
               (in_funct3 == 3'b010) ? |in_alu[1:0] :
               (in_funct3 == 3'b011) || (in_funct3[2:1] == 2'b11);
    byte_v = 8'(dmem_rsp_data >> {ld_off, 3'b000});
    half_v = ld_off[1] ? dmem_rsp_data[31:16] : dmem_rsp_data[15:0];
    load_data = ld_f3[1] ? dmem_rsp_data :
                ld_f3[0] ? {{16{~ld_f3[2] & half_v[15]}}, half_v} :
                           {{24{~ld_f3[2] & byte_v[7]}}, byte_v};
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      ld_rd <= '0;
      ld_we <= 1'b0;
      ld_f3 <= '0;
      ld_off <= '0;
      write_enable <= 1'b0;
      addr_rd <= '0;
      data_rd <= '0;
      err_misalign <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      err_misalign <= 1'b0;
      if (state == IDLE) begin
        if (accept && in_wb_sel == 2'd1) begin
          if (misalign) err_misalign <= 1'b1;
          else begin
            state <= WAIT_RSP;
            cnt <= '0;
            ld_rd <= in_rd;
            ld_we <= in_reg_we;
            ld_f3 <= in_funct3;
            ld_off <= in_alu[1:0];
          end
        end else if (accept && in_wb_sel != 2'd3 && in_reg_we && in_rd != 5'd0) begin
          write_enable <= 1'b1;
          addr_rd <= in_rd;
          data_rd <= (in_wb_sel == 2'd2) ? in_pc + 32'd4 : in_alu;
        end
      end else if (dmem_rsp_valid) begin
        state <= IDLE;
        if (ld_we && ld_rd != 5'd0) begin
          write_enable <= 1'b1;
          addr_rd <= ld_rd;
          data_rd <= load_data;
        end
      end else begin
        // The response check above takes priority, so a reply in the final cycle still commits.
        cnt <= cnt + 8'd1;
        if (cnt + 8'd1 == 8'(RSP_TIMEOUT)) begin
          state <= IDLE;
          err_timeout <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: random and directed stimulus checked against a transaction-level model.
module tb_writeback_stage;
  localparam int TO = 15;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0, in_reg_we = 1'b0, dmem_rsp_valid = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [1:0]  in_wb_sel = '0;
  logic [31:0] in_alu = '0, in_pc = '0, dmem_rsp_data = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_ready, write_enable, err_misalign, err_timeout;
  logic [4:0]  addr_rd;
  logic [31:0] data_rd;
`ifdef WB_BYPASS_EN
  logic        byp_valid;
  logic [4:0]  byp_rd;
  logic [31:0] byp_data;
`endif
  always #5 clock = ~clock;
  writeback_stage #(.RSP_TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_we(in_reg_we), .in_rd(in_rd), .in_wb_sel(in_wb_sel), .in_alu(in_alu),
    .in_pc(in_pc), .in_funct3(in_funct3), .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rsp_data(dmem_rsp_data), .write_enable(write_enable), .addr_rd(addr_rd),
    .data_rd(data_rd), .err_misalign(err_misalign),
`ifdef WB_BYPASS_EN
    .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data),
`endif
    .err_timeout(err_timeout)
  );
  int n_checks = 0, n_fail = 0;
  bit          m_pend, m_pwe, m_we, m_mis, m_to;
  int          m_wait;
  logic [4:0]  m_prd, m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_off;
  logic [31:0] m_data;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit bad_load(input logic [2:0] f3, input logic [1:0] off);
    int size = 1 << f3[1:0];
    return f3 == 3 || f3 == 6 || f3 == 7 || (int'(off) % size) != 0;
  endfunction
  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rsp);
    int nb = 1 << f3[1:0];
    logic [31:0] mask = (nb == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nb)) - 32'h1;
    logic [31:0] val = (rsp >> (8 * int'(off))) & mask;
    if (!f3[2] && val > (mask >> 1)) val = val | ~mask;
    return val;
  endfunction
  task automatic commit(input logic [4:0] rd, input logic [31:0] d);
    m_we = 1;
    m_rd = rd;
    m_data = d;
  endtask
  task automatic compare_all();
    check("in_ready", 32'(in_ready), 32'(!m_pend));
    check("write_enable", 32'(write_enable), 32'(m_we));
    check("addr_rd", 32'(addr_rd), 32'(m_rd));
    check("data_rd", data_rd, m_data);
    check("err_misalign", 32'(err_misalign), 32'(m_mis));
    check("err_timeout", 32'(err_timeout), 32'(m_to));
`ifdef WB_BYPASS_EN
    check("byp_valid", 32'(byp_valid), 32'(m_we));
    check("byp_rd", 32'(byp_rd), 32'(m_rd));
    check("byp_data", byp_data, m_data);
`endif
  endtask
  task automatic step(input bit v, input bit we, input logic [4:0] rd, input logic [1:0] sel,
                      input logic [31:0] alu, input logic [31:0] pc, input logic [2:0] f3,
                      input bit rv, input logic [31:0] rsp);
    in_valid = v; in_reg_we = we; in_rd = rd; in_wb_sel = sel; in_alu = alu;
    in_pc = pc; in_funct3 = f3; dmem_rsp_valid = rv; dmem_rsp_data = rsp;
    m_we = 0;
    m_mis = 0;
    if (!m_pend) begin
      if (v && sel == 1) begin
        if (bad_load(f3, alu[1:0])) m_mis = 1;
        else begin
          m_pend = 1; m_wait = 0; m_prd = rd; m_pwe = we; m_f3 = f3; m_off = alu[1:0];
        end
      end else if (v && (sel == 0 || sel == 2) && we && rd != 0)
        commit(rd, sel == 2 ? pc + 32'd4 : alu);
    end else if (rv) begin
      m_pend = 0;
      if (m_pwe && m_prd != 0) commit(m_prd, extract(m_f3, m_off, rsp));
    end else begin
      m_wait++;
      if (m_wait == TO) begin
        m_pend = 0;
        m_to = 1;
      end
    end
    @(posedge clock);
    #1;
    compare_all();
  endtask
  task automatic idle(input bit rv = 0, input logic [31:0] rsp = '0);
    step(0, 0, 0, 0, 0, 0, 0, rv, rsp);
  endtask
  task automatic do_reset();
    in_valid = 0;
    dmem_rsp_valid = 0;
    #2 reset_n = 0;
    m_pend = 0; m_wait = 0; m_we = 0; m_rd = 0; m_data = 0; m_mis = 0; m_to = 0;
    #1 compare_all();
    @(posedge clock);
    #1 reset_n = 1;
  endtask
  initial begin
    do_reset();
    idle();
    check("ready_after_reset", 32'(in_ready), 32'd1);
    step(1, 1, 5, 0, 32'h1234_5678, 0, 0, 0, 0);
    check("alu_we", 32'(write_enable), 32'd1);
    check("alu_rd", 32'(addr_rd), 32'd5);
    check("alu_data", data_rd, 32'h1234_5678);
    step(1, 1, 7, 1, 32'h0000_1003, 0, 3'b000, 0, 0);
    idle();
    idle();
    check("lb_ready_low", 32'(in_ready), 32'd0);
    idle(1, 32'h80FF_FF7F);
    check("lb_data", data_rd, 32'hFFFF_FF80);
    check("lb_ready", 32'(in_ready), 32'd1);
    step(1, 1, 9, 1, 32'h0000_2002, 0, 3'b101, 0, 0);
    idle(1, 32'hBEEF_0001);
    check("lhu_data", data_rd, 32'h0000_BEEF);
    step(1, 1, 9, 1, 32'h0000_2002, 0, 3'b010, 0, 0);
    check("lw_mis", 32'(err_misalign), 32'd1);
    check("lw_mis_nowe", 32'(write_enable), 32'd0);
    check("lw_mis_ready", 32'(in_ready), 32'd1);
    idle();
    check("mis_pulse_end", 32'(err_misalign), 32'd0);
    step(1, 1, 0, 2, 0, 32'hFFFF_FFFC, 0, 0, 0);
    check("pc4_rd0_nowe", 32'(write_enable), 32'd0);
    step(1, 1, 1, 2, 0, 32'hFFFF_FFFC, 0, 0, 0);
    check("pc4_wrap", data_rd, 32'h0000_0000);
    step(1, 1, 3, 3, 32'hDEAD_BEEF, 0, 0, 0, 0);
    check("sel3_nowe", 32'(write_enable), 32'd0);
    step(1, 1, 4, 1, 32'h100, 0, 3'b010, 0, 0);
    for (int i = 0; i < TO - 1; i++) idle();
    check("edge_ready_low", 32'(in_ready), 32'd0);
    idle(1, 32'h0BAD_F00D);
    check("edge_rsp_wins", 32'(write_enable), 32'd1);
    check("edge_no_timeout", 32'(err_timeout), 32'd0);
    step(1, 1, 6, 1, 32'h104, 0, 3'b000, 0, 0);
    for (int i = 0; i < TO - 1; i++) idle();
    idle();
    check("timeout_set", 32'(err_timeout), 32'd1);
    check("timeout_ready", 32'(in_ready), 32'd1);
    idle(1, 32'h1111_1111);
    check("late_rsp_ignored", 32'(write_enable), 32'd0);
    step(1, 1, 8, 1, 32'h200, 0, 3'b010, 0, 0);
    idle();
    do_reset();
    idle(1, 32'h2222_2222);
    check("post_reset_nowe", 32'(write_enable), 32'd0);
    check("post_reset_data", data_rd, 32'd0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 1500; i++)
        step($urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom_range(0, 31)),
             2'($urandom_range(0, 3)), $urandom, $urandom, 3'($urandom_range(0, 7)),
             $urandom_range(0, 3) == 0, $urandom);
      do_reset();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
